booth_acc_stage: RTL and testbench

Sequential accumulation stage directly downstream of the 64x64 signed Booth multiplier. It accepts a stream of signed 128-bit products over a valid/ready handshake and sums them into a guard-extended accumulator. Each frame is terminated by `in_last`, after which it presents one registered dot-product result with a beat count and a sticky overflow flag. It holds that result until the consumer takes it, then starts the next frame.

---
 rtl/booth_acc_stage.sv | 80 ++++++++
 tb/tb_booth_acc_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_acc_stage.sv
// booth_acc_stage: accumulates signed Booth products per in_last-terminated frame and holds one result.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          product beat handshake; in_product (PW, signed), in_last ends the frame
//   clr                        synchronous abort of the partial frame (ignored while holding a result)
//   out_valid/out_ready        result handshake
//   out_sum (AW), out_count (CW), out_ovf   frame sum, beat count, sticky signed overflow
module booth_acc_stage #(
  parameter int PW = 128,
  parameter int AW = 136,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_product,
  input  logic          in_last,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] acc, acc_nxt, acc_base, ext, sum;
  logic [CW-1:0] cnt, cnt_nxt, cnt_base, cnt_inc;
  logic ovf, ovf_nxt, ovf_base, ovf_upd;
  logic take, fin, clr_acc;
  logic signed [PW-1:0] prod_s;
  assign prod_s = in_product;
  assign ext = AW'(prod_s);
  assign in_ready = state == ACC;
  assign out_valid = state == HOLD;
  assign take = in_valid && in_ready;
  assign fin = take && in_last;
  assign clr_acc = clr && in_ready;
  always_comb begin
    acc_base = clr_acc ? '0 : acc;
    cnt_base = clr_acc ? '0 : cnt;
    ovf_base = clr_acc ? 1'b0 : ovf;
    sum = acc_base + ext;
    // cnt saturates instead of wrapping so very long frames never report a small count
    cnt_inc = &cnt_base ? cnt_base : cnt_base + CW'(1);
    // two's-complement overflow: like-signed operands producing a differently signed result
    ovf_upd = ovf_base | ((acc_base[AW-1] == ext[AW-1]) && (sum[AW-1] != acc_base[AW-1]));
    state_nxt = fin ? HOLD : (state == HOLD && out_ready) ? ACC : state;
    acc_nxt = take ? (in_last ? '0 : sum) : acc_base;
    cnt_nxt = take ? (in_last ? '0 : cnt_inc) : cnt_base;
    ovf_nxt = take ? (in_last ? 1'b0 : ovf_upd) : ovf_base;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_sum <= '0;
      out_count <= '0;
      out_ovf <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
      if (fin) begin
        out_sum <= sum;
        out_count <= cnt_inc;
        out_ovf <= ovf_upd;
      end
    end
  end
endmodule

// File: tb/tb_booth_acc_stage.sv
// tb_booth_acc_stage: scoreboard bench driving a default-width and a 130-bit accumulator stage in lockstep.
module tb_booth_acc_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [127:0] in_product = '0;
  logic in_ready_a, out_valid_a, out_ovf_a, in_ready_b, out_valid_b, out_ovf_b;
  logic [135:0] out_sum_a;
  logic [129:0] out_sum_b;
  logic [15:0] out_count_a, out_count_b;
  always #5 clk = ~clk;

  booth_acc_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_product(in_product), .in_last(in_last), .clr(clr), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a), .out_ovf(out_ovf_a)
  );
  booth_acc_stage #(.AW(130)) u_dut130 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_product(in_product), .in_last(in_last), .clr(clr), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  typedef struct {
    logic [135:0] s136;
    logic [129:0] s130;
    logic [15:0] c;
    logic o136;
    logic o130;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic rnd_ready = 1'b0;
  logic signed [255:0] m136, m130;
  logic [15:0] mcnt;
  logic mo136, mo130;

  task automatic chk(input string name, input logic ok, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reduce an exact integer to a w-bit two's-complement value.
  function automatic logic signed [255:0] wrap(input logic signed [255:0] x, input int w);
    logic signed [255:0] t;
    t = x <<< (256 - w);
    return t >>> (256 - w);
  endfunction

  task automatic model_clear();
    m136 = '0; m130 = '0; mcnt = '0; mo136 = 1'b0; mo130 = 1'b0;
  endtask

  // Reference: exact signed sum per frame, overflow when the exact partial sum leaves the w-bit range.
  task automatic model_accept(input logic [127:0] p, input logic last, input logic c);
    logic signed [255:0] ps, e;
    exp_t x;
    if (c) model_clear();
    ps = {{128{p[127]}}, p};
    e = m136 + ps;
    if (wrap(e, 136) != e) mo136 = 1'b1;
    m136 = wrap(e, 136);
    e = m130 + ps;
    if (wrap(e, 130) != e) mo130 = 1'b1;
    m130 = wrap(e, 130);
    if (mcnt != 16'hffff) mcnt = mcnt + 16'd1;
    if (last) begin
      x.s136 = m136[135:0]; x.s130 = m130[129:0]; x.c = mcnt; x.o136 = mo136; x.o130 = mo130;
      q.push_back(x);
      model_clear();
    end
  endtask

  task automatic send(input logic [127:0] p, input logic last, input logic c);
    int t;
    in_valid = 1'b1; in_product = p; in_last = last; clr = c;
    t = 0;
    @(negedge clk);
    while (!in_ready_a && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready_a) chk("accept_timeout", 1'b0, 136'(in_ready_a), 136'd1);
    else model_accept(p, last, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the result is presented it must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_valid", in_ready_a == !out_valid_a, 136'(in_ready_a), 136'(!out_valid_a));
      chk("lockstep_valid", out_valid_a == out_valid_b, 136'(out_valid_b), 136'(out_valid_a));
      if (out_valid_a) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1'b0, out_sum_a, 136'd0);
        end else begin
          chk("sum136", out_sum_a == q[0].s136, out_sum_a, q[0].s136);
          chk("sum130", out_sum_b == q[0].s130, 136'(out_sum_b), 136'(q[0].s130));
          chk("count", out_count_a == q[0].c && out_count_b == q[0].c, 136'(out_count_a), 136'(q[0].c));
          chk("ovf136", out_ovf_a == q[0].o136, 136'(out_ovf_a), 136'(q[0].o136));
          chk("ovf130", out_ovf_b == q[0].o130, 136'(out_ovf_b), 136'(q[0].o130));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  logic pv = 1'b0, pl = 1'b0;
  logic [127:0] pp = '0;
  always @(posedge clk) begin
    if (pv && in_valid) assert (in_product == pp && in_last == pl) else $error("producer rule broken");
    pv <= in_valid && !in_ready_a && rst_n;
    pp <= in_product;
    pl <= in_last;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    logic [127:0] p;
    int len, tt;
    model_clear();
    #23;
    chk("rst_in_ready", in_ready_a == 1'b1, 136'(in_ready_a), 136'd1);
    chk("rst_out_valid", out_valid_a == 1'b0, 136'(out_valid_a), 136'd0);
    chk("rst_out_sum", out_sum_a == '0 && out_count_a == '0 && out_ovf_a == 1'b0, out_sum_a, 136'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);
    out_ready = 1'b1;
    send(128'd6, 0, 0); send(-128'sd10, 0, 0); send(128'd25, 1, 0);
    cycles(3);
    send(128'd1 << 126, 0, 0); send(128'd1 << 127, 0, 0); send({1'b0, {127{1'b1}}}, 1, 0);
    cycles(2);
    for (int i = 0; i < 5; i++) send({1'b0, {127{1'b1}}}, i == 4, 0);
    send(128'd1, 1, 0);
    cycles(2);
    out_ready = 1'b0;
    send(128'd7, 1, 0);
    fork
      send(128'd100, 1, 0);
      begin
        cycles(5);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
      end
    join
    cycles(3);
    out_ready = 1'b1;
    cycles(2);
    send(128'd50, 0, 0); send(128'd60, 0, 0); send(128'd9, 1, 1);
    cycles(1);
    out_ready = 1'b0;
    send(128'd5, 1, 0);
    clr = 1'b1;
    cycles(3);
    clr = 1'b0;
    cycles(1);
    out_ready = 1'b1;
    cycles(2);
    send(128'd11, 0, 0); send(128'd12, 0, 0);
    #3 rst_n = 1'b0;
    model_clear();
    q.delete();
    cycles(2);
    rst_n = 1'b1;
    send(128'd4, 1, 0);
    cycles(2);
    out_ready = 1'b0;
    send(128'd8, 1, 0);
    cycles(2);
    #2 rst_n = 1'b0;
    q.delete();
    model_clear();
    #1;
    chk("rst_hold_valid", out_valid_a == 1'b0 && out_valid_b == 1'b0, 136'(out_valid_a), 136'd0);
    chk("rst_hold_sum", out_sum_a == '0 && out_sum_b == '0, out_sum_a, 136'd0);
    chk("rst_hold_ready", in_ready_a == 1'b1, 136'(in_ready_a), 136'd1);
    cycles(2);
    rst_n = 1'b1;
    rnd_ready = 1'b1;
    for (int f = 0; f < 150; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        p = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) p = 128'($signed($urandom_range(0, 200)) - 100);
        if ($urandom_range(0, 2) == 0) cycles($urandom_range(1, 2));
        send(p, b == len - 1, $urandom_range(0, 14) == 0);
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    tt = 0;
    while (q.size() != 0 && tt < 100) begin
      tt++;
      @(posedge clk);
    end
    #1;
    chk("drain", q.size() == 0, 136'(q.size()), 136'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
